ins_mem_responder: RTL and testbench

Instruction-memory responder for the CPU's fetch handshake. It accepts a fetch request (`en_ram_in` high with `addr`), waits a programmable number of cycles, then returns the 16-bit instruction on `ins` with a one-cycle `en_ram_out` strobe. A side load port lets the bench or boot logic write program words into the array. It sits between the CPU's `addr` / `en_ram_in` outputs and its `ins` / `en_ram_out` inputs.

---
 rtl/ins_mem_responder.sv | 95 +++++++++
 tb/tb_ins_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_responder.sv
// Instruction-memory responder: accepts a fetch, waits LATENCY cycles, then returns
// the addressed word with a one-cycle strobe. A side port loads program words.
module ins_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic              en_ram_in,
    output logic [15:0]       ins,
    output logic              en_ram_out,
    output logic              addr_err,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  cnt;
    logic [15:0] addr_q;
    logic [15:0] rd_word;
    logic        accept;
    logic        hit;

    logic [15:0] mem [DEPTH];

    // Upper address bits must be zero for the index to land inside the array.
    function automatic logic in_array(input logic [15:0] a);
        return (a[15:ADDR_W] == '0);
    endfunction

    assign accept  = (state == S_IDLE) && en_ram_in;
    assign rd_word = mem[addr_q[ADDR_W-1:0]];
    assign hit     = in_array(addr_q);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (en_ram_in) state_nxt = (LATENCY > 1) ? S_WAIT : S_RESP;
            S_WAIT: if (cnt == WAIT_LAST) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture: the address is held for the whole transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= addr;
        end
    end

    // Program load port; a same-edge read still sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Control and response stage: outputs are registered off the RESP state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            en_ram_out <= 1'b0;
            addr_err   <= 1'b0;
            ins        <= 16'h0000;
        end else begin
            state      <= state_nxt;
            busy       <= (state != S_IDLE);
            en_ram_out <= (state == S_RESP);
            addr_err   <= (state == S_RESP) && !hit;
            if (accept) begin
                cnt <= 4'd0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (state == S_RESP) begin
                ins <= hit ? rd_word : 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_ins_mem_responder.sv
// Directed bench for ins_mem_responder: a LATENCY=2 instance driven from a vector
// table plus hand-written sequences, and a LATENCY=1 instance.
module tb_ins_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [15:0] addr;
    logic        en_ram_in;
    logic [15:0] ins;
    logic        en_ram_out;
    logic        addr_err;
    logic        busy;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    logic [15:0] addr_l1;
    logic        en_ram_in_l1;
    logic [15:0] ins_l1;
    logic        en_ram_out_l1;
    logic        addr_err_l1;
    logic        busy_l1;
    logic        load_en_l1;
    logic [7:0]  load_addr_l1;
    logic [15:0] load_data_l1;

    int checks = 0;
    int errors = 0;

    ins_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .addr(addr), .en_ram_in(en_ram_in),
        .ins(ins), .en_ram_out(en_ram_out), .addr_err(addr_err), .busy(busy),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    ins_mem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .addr(addr_l1), .en_ram_in(en_ram_in_l1),
        .ins(ins_l1), .en_ram_out(en_ram_out_l1), .addr_err(addr_err_l1), .busy(busy_l1),
        .load_en(load_en_l1), .load_addr(load_addr_l1), .load_data(load_data_l1)
    );

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] exp_ins;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load2(input logic [7:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic load1(input logic [7:0] a, input logic [15:0] d);
        load_en_l1 = 1'b1; load_addr_l1 = a; load_data_l1 = d;
        step();
        load_en_l1 = 1'b0;
    endtask

    // Single fetch on the LATENCY=2 instance; request sampled at edge t,
    // strobe expected only in the cycle after edge t+2.
    task automatic fetch(input string name, input logic [15:0] a,
                         input logic [15:0] exp_ins, input logic exp_err);
        addr = a; en_ram_in = 1'b1;
        step();
        en_ram_in = 1'b0; addr = 16'hDEAD;
        chk({name, "_t0_strobe"}, en_ram_out, 0);
        step();
        chk({name, "_t1_strobe"}, en_ram_out, 0);
        chk({name, "_t1_busy"}, busy, 1);
        step();
        chk({name, "_t2_strobe"}, en_ram_out, 1);
        chk({name, "_t2_ins"}, ins, exp_ins);
        chk({name, "_t2_err"}, addr_err, exp_err);
        chk({name, "_t2_busy"}, busy, 1);
        step();
        chk({name, "_t3_strobe"}, en_ram_out, 0);
        chk({name, "_t3_err"}, addr_err, 0);
        chk({name, "_t3_busy"}, busy, 0);
        chk({name, "_t3_hold"}, ins, exp_ins);
    endtask

    initial begin
        vecs[0] = '{"v_a55a",  16'h0005, 16'hA55A, 1'b0};
        vecs[1] = '{"v_oor",   16'h0100, 16'h0000, 1'b1};
        vecs[2] = '{"v_beef",  16'h0003, 16'hBEEF, 1'b0};
        vecs[3] = '{"v_top",   16'h00FF, 16'h7E57, 1'b0};
        vecs[4] = '{"v_ffff",  16'hFFFF, 16'h0000, 1'b1};
        vecs[5] = '{"v_zero",  16'h0000, 16'h0100, 1'b0};

        rst = 1'b0;
        addr = '0; en_ram_in = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        addr_l1 = '0; en_ram_in_l1 = 1'b0; load_en_l1 = 1'b0; load_addr_l1 = '0; load_data_l1 = '0;

        #12;
        chk("rst_ins", ins, 16'h0000);
        chk("rst_strobe", en_ram_out, 0);
        chk("rst_err", addr_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_l1_busy", busy_l1, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_strobe", en_ram_out, 0);
        end

        load2(8'd5, 16'hA55A);
        load2(8'd0, 16'h0100);
        load2(8'd1, 16'h0101);
        load2(8'd2, 16'h0102);
        load2(8'd3, 16'hBEEF);
        load2(8'd7, 16'h2222);
        load2(8'd255, 16'h7E57);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].name, vecs[i].a, vecs[i].exp_ins, vecs[i].exp_err);
        end

        // Back-to-back with the request held high; address steps after each strobe.
        addr = 16'h0000; en_ram_in = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_gap", en_ram_out, 0);
            step();
            chk("b2b_strobe", en_ram_out, 1);
            chk("b2b_ins", ins, 16'h0100 + 16'(i));
            if (i == 2) en_ram_in = 1'b0;
            else addr = 16'(i + 1);
            step();
            chk("b2b_clear", en_ram_out, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_no_extra", en_ram_out, 0);
        end

        // Load hits the same index on the edge that captures ins.
        addr = 16'h0007; en_ram_in = 1'b1;
        step();
        en_ram_in = 1'b0;
        step();
        load_en = 1'b1; load_addr = 8'd7; load_data = 16'h1111;
        step();
        load_en = 1'b0;
        chk("coll_strobe", en_ram_out, 1);
        chk("coll_old", ins, 16'h2222);
        step();
        fetch("coll_new", 16'h0007, 16'h1111, 1'b0);

        // Reset in the middle of a wait aborts the fetch.
        addr = 16'h0005; en_ram_in = 1'b1;
        step();
        en_ram_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_ins", ins, 16'h0000);
        chk("mid_rst_strobe", en_ram_out, 0);
        chk("mid_rst_err", addr_err, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_strobe", en_ram_out, 0);
            chk("post_rst_busy", busy, 0);
        end
        fetch("post_rst_fetch", 16'h0005, 16'hA55A, 1'b0);

        // LATENCY=1 instance.
        load1(8'd9, 16'h1234);
        load1(8'd10, 16'h5678);
        addr_l1 = 16'h0009; en_ram_in_l1 = 1'b1;
        step();
        chk("l1_t0_strobe", en_ram_out_l1, 0);
        addr_l1 = 16'h000A;
        step();
        chk("l1_t1_strobe", en_ram_out_l1, 1);
        chk("l1_t1_ins", ins_l1, 16'h1234);
        chk("l1_t1_err", addr_err_l1, 0);
        chk("l1_t1_busy", busy_l1, 1);
        en_ram_in_l1 = 1'b0;
        step();
        chk("l1_t2_strobe", en_ram_out_l1, 0);
        chk("l1_t2_busy", busy_l1, 0);
        chk("l1_t2_hold", ins_l1, 16'h1234);
        step();
        chk("l1_t3_strobe", en_ram_out_l1, 0);
        en_ram_in_l1 = 1'b1;
        step();
        en_ram_in_l1 = 1'b0;
        step();
        chk("l1_second_strobe", en_ram_out_l1, 1);
        chk("l1_second_ins", ins_l1, 16'h5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
